ram_4k_arbiter: RTL
===================

Name: ram_4k_arbiter

Overview:
- Two-port arbiter and sequencer in front of the 4K x 16 RAM (12-bit address, 16-bit data, W/R/E controls, rising-edge write, read data valid while R is high).
- Port A is the instruction-fetch requester. Port B is the data load/store requester.
- Grants one transaction at a time with round-robin priority and drives the RAM control strobes.
- Captures read data and returns it with a one-cycle acknowledge.

Parameters:
- ADDR_W, 12, RAM address width.
- DATA_W, 16, RAM data width.

Ports:
- CLK  in  1  system clock, rising-edge active.
- RST_N  in  1  asynchronous active-low reset.
- A_REQ  in  1  port A request; held high until A_ACK.
- A_WE  in  1  port A write enable (1 = write, 0 = read); qualified by A_REQ.
- A_ADDR  in  ADDR_W  port A address.
- A_WDATA  in  DATA_W  port A write data.
- A_ACK  out  1  one-cycle acknowledge for port A.
- A_RDATA  out  DATA_W  port A read data; valid with A_ACK and held until the next port A read.
- B_REQ, B_WE, B_ADDR, B_WDATA, B_ACK, B_RDATA: same as the A_* ports, for port B.
- MEM_E  out  1  RAM enable.
- MEM_W  out  1  RAM write strobe.
- MEM_R  out  1  RAM read strobe.
- MEM_ADDR  out  ADDR_W  RAM address.
- MEM_D  out  DATA_W  RAM write data.
- MEM_Q  in  DATA_W  RAM read data.
- BUSY  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset: RST_N low asynchronously forces the following:
  - FSM to IDLE.
  - A_ACK, B_ACK, MEM_E, MEM_W, MEM_R and BUSY to 0.
  - MEM_ADDR, MEM_D, A_RDATA and B_RDATA to 0.
  - Priority pointer LAST to B, so A wins the first tie.
- Reset mid-transaction: MEM_W drops in the same instant. No write reaches the RAM on the following edge, and no ACK is issued.
- FSM states and transitions:
  - IDLE: sample A_REQ and B_REQ.
    - Neither high: stay in IDLE.
    - One high: grant that port.
    - Both high: grant the port that is not LAST.
    - On grant: latch the granted port's WE, ADDR and WDATA into internal registers, record the granted port in GNT, and go to ACCESS.
  - ACCESS (exactly 1 cycle):
    - MEM_E = 1, MEM_ADDR = latched address, MEM_D = latched data.
    - MEM_W = latched WE; MEM_R = not latched WE.
    - The RAM write occurs on the edge that ends ACCESS.
    - For a read, MEM_Q is captured into the granted port's RDATA register on that same edge.
    - Go to RESP.
  - RESP (exactly 1 cycle):
    - MEM_E, MEM_W and MEM_R are 0.
    - The ACK of the granted port is 1; the other ACK is 0.
    - LAST is updated to GNT on the edge that ends RESP.
    - Go to IDLE.
- Timing: a request sampled in IDLE on cycle N is acknowledged in cycle N+2. The sustained throughput is one transaction per 3 cycles.
- Handshake rules:
  - A requester drops REQ on the edge that ends its ACK cycle. REQ still high in the following IDLE is a new request.
  - Changes to REQ, WE, ADDR or WDATA after the grant are ignored. The latched transaction completes and ACK is still issued.
- RDATA registers: a write transaction leaves that port's RDATA unchanged. The non-granted port's RDATA never changes.
- Memory outputs: MEM_* outputs are decoded from registered state and latched fields only. There is no combinational path from the *_REQ inputs to MEM_*.
- Fairness: with both ports continuously requesting, grants alternate A, B, A, B, and so on. Neither port waits more than one transaction.
- Address width: full ADDR_W address space, no wrap logic. The RAM decodes the whole 12-bit address.

Optional Feature:
- Macro: RAM_ARB_FETCH_RO_EN.
- Defined:
  - Port A is read-only, and an extra output A_ERR (1 bit, reset 0) exists.
  - A granted port A transaction with A_WE = 1 passes through ACCESS with MEM_E, MEM_W and MEM_R all held at 0.
  - In RESP it asserts A_ACK together with A_ERR = 1 for that one cycle. A_RDATA and RAM contents are unchanged.
  - Arbitration and LAST update are as normal.
- Not defined:
  - The A_ERR port is absent.
  - Port A writes are performed exactly like port B writes.

Test Plan:
- Reset: hold RST_N = 0 for 3 cycles with A_REQ = 1 -> all outputs 0 and BUSY = 0. First grant after release goes to A.
- Single write then read: B writes 16'h1234 to 12'h0A5 (B_ACK 2 cycles after sample, MEM_W high for exactly 1 cycle). B then reads 12'h0A5 -> B_RDATA = 16'h1234 with B_ACK, and A_RDATA stays 0.
- Tie and round-robin: A reads 12'h020 and B reads 12'h7E0, both held continuously -> grants A, B, A, B. Each ACK is 3 cycles after the previous one.
- Reset mid-ACCESS: assert RST_N low during a B write of 16'hBEEF to 12'hFFF -> no ACK. A later read of 12'hFFF returns the prior value.
- Late input change: change B_ADDR from 12'h100 to 12'h200 during ACCESS -> MEM_ADDR stays 12'h100 and B_ACK is still asserted.
- RAM_ARB_FETCH_RO_EN defined: A writes 16'h5555 to 12'h010 -> A_ACK = 1 and A_ERR = 1, MEM_W never high. A later B read of 12'h010 returns the old value.

Source files
------------

// File: rtl/ram_4k_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a 4K x 16 synchronous-write RAM.
// Optional RAM_ARB_FETCH_RO_EN: port A becomes read-only and reports write attempts on a_err.
module ram_4k_arbiter #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
`ifdef RAM_ARB_FETCH_RO_EN
  output logic              a_err,
`endif
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_e,
  output logic              mem_w,
  output logic              mem_r,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

`ifdef RAM_ARB_FETCH_RO_EN
  localparam logic FETCH_RO = 1'b1;
`else
  localparam logic FETCH_RO = 1'b0;
`endif
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t            state, state_d;
  txn_t              txn, txn_d;
  logic              gnt, gnt_d;
  logic              last, last_d;
  logic              blk, blk_d;
  logic              pick_b;
  logic              a_ack_d, b_ack_d;
  logic              mem_e_d, mem_w_d, mem_r_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_d_d;
  logic [DATA_W-1:0] a_rdata_d, b_rdata_d;
`ifdef RAM_ARB_FETCH_RO_EN
  logic              a_err_d;
`endif

  // Next-state and next-output decode; strobes for ACCESS are prepared on the grant edge
  always_comb begin
    state_d    = state;
    txn_d      = txn;
    gnt_d      = gnt;
    last_d     = last;
    blk_d      = blk;
    pick_b     = 1'b0;
    a_ack_d    = 1'b0;
    b_ack_d    = 1'b0;
    mem_e_d    = 1'b0;
    mem_w_d    = 1'b0;
    mem_r_d    = 1'b0;
    mem_addr_d = mem_addr;
    mem_d_d    = mem_d;
    a_rdata_d  = a_rdata;
    b_rdata_d  = b_rdata;
`ifdef RAM_ARB_FETCH_RO_EN
    a_err_d    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (a_req || b_req) begin
          // B wins only when A is idle or A was served last
          pick_b     = b_req && (!a_req || (last == PORT_A));
          gnt_d      = pick_b;
          txn_d      = pick_b ? {b_we, b_addr, b_wdata} : {a_we, a_addr, a_wdata};
          blk_d      = FETCH_RO && !pick_b && txn_d.we;
          mem_e_d    = !blk_d;
          mem_w_d    = txn_d.we && !blk_d;
          mem_r_d    = !txn_d.we && !blk_d;
          mem_addr_d = txn_d.addr;
          mem_d_d    = txn_d.wdata;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (!txn.we) begin
          if (gnt == PORT_B) b_rdata_d = mem_q;
          else               a_rdata_d = mem_q;
        end
        a_ack_d = (gnt == PORT_A);
        b_ack_d = (gnt == PORT_B);
`ifdef RAM_ARB_FETCH_RO_EN
        a_err_d = blk;
`endif
        state_d = RESP;
      end
      RESP: begin
        last_d  = gnt;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // All state and outputs registered; reset clears strobes asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      txn      <= '0;
      gnt      <= PORT_A;
      last     <= PORT_B;
      blk      <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
      mem_e    <= 1'b0;
      mem_w    <= 1'b0;
      mem_r    <= 1'b0;
      mem_addr <= '0;
      mem_d    <= '0;
      a_rdata  <= '0;
      b_rdata  <= '0;
      busy     <= 1'b0;
`ifdef RAM_ARB_FETCH_RO_EN
      a_err    <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      txn      <= txn_d;
      gnt      <= gnt_d;
      last     <= last_d;
      blk      <= blk_d;
      a_ack    <= a_ack_d;
      b_ack    <= b_ack_d;
      mem_e    <= mem_e_d;
      mem_w    <= mem_w_d;
      mem_r    <= mem_r_d;
      mem_addr <= mem_addr_d;
      mem_d    <= mem_d_d;
      a_rdata  <= a_rdata_d;
      b_rdata  <= b_rdata_d;
      busy     <= (state_d != IDLE);
`ifdef RAM_ARB_FETCH_RO_EN
      a_err    <= a_err_d;
`endif
    end
  end

endmodule
